// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: shared definitions for the HI/LO register unit.
//   - HI/LO slice boundaries of the 64-bit mult/div result
//   - slot_t: one pipeline slot {valid, we_hi, we_lo, hi, lo}
//   - hilo_op_e: E-stage write op, decoded with hilo_we > mthi > mtlo priority
//   - enc_entry(): builds the E-stage slot entry from the decoded op
package hilo_unit_pkg;

  localparam int XLEN   = 32;
  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  typedef struct packed {
    logic            valid;
    logic            we_hi;
    logic            we_lo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } slot_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_HILO = 2'd1,
    OP_MTHI = 2'd2,
    OP_MTLO = 2'd3
  } hilo_op_e;

  // Several write strobes at once is illegal; resolve deterministically.
  function automatic hilo_op_e dec_op(input logic we, input logic mthi, input logic mtlo);
    if (we)        return OP_HILO;
    else if (mthi) return OP_MTHI;
    else if (mtlo) return OP_MTLO;
    else           return OP_NONE;
  endfunction

  function automatic slot_t enc_entry(input hilo_op_e op, input logic [63:0] res,
                                      input logic [XLEN-1:0] rs);
    slot_t e;
    e = '0;
    case (op)
      OP_HILO: begin
        e.valid = 1'b1; e.we_hi = 1'b1; e.we_lo = 1'b1;
        e.hi = res[HI_MSB:HI_LSB];
        e.lo = res[LO_MSB:LO_LSB];
      end
      OP_MTHI: begin e.valid = 1'b1; e.we_hi = 1'b1; e.hi = rs; end
      OP_MTLO: begin e.valid = 1'b1; e.we_lo = 1'b1; e.lo = rs; end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/hilo_slot_reg.sv
// hilo_slot_reg: one HI/LO pipeline slot register.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear slot at this edge (beats hold)
//   i_hold     : keep current contents
//   i_d        : entry loaded when neither clear nor hold (bubble = all-zero)
//   o_q        : current slot contents
module hilo_slot_reg
  import hilo_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_clr,
  input  logic  i_hold,
  input  slot_t i_d,
  output slot_t o_q
);

  slot_t r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_q <= '0;
    else if (!i_hold) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural registers with an M/W write pipeline and
// E-stage read forwarding for MFHI/MFLO.
//   clk, rst                 : clock, synchronous active-high reset
//   hilo_we_E, hilo_in_E     : mult/div result written to HI and LO
//   mthi_E, mtlo_E, rs_val_E : single-half writes from rs
//   mfhi_E, mflo_E           : read requests, result on hilo_rd_E
//   div_stallE, stallM       : divider busy / hold M slot
//   flushM, flushW           : kill entry entering M / W
//   hi_o, lo_o               : architectural HI/LO
//   hilo_busy_E              : unforwardable read hazard (FWD_EN=0 only)
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hilo_we_E,
  input  logic [63:0]     hilo_in_E,
  input  logic            mthi_E,
  input  logic            mtlo_E,
  input  logic [XLEN-1:0] rs_val_E,
  input  logic            mfhi_E,
  input  logic            mflo_E,
  input  logic            div_stallE,
  input  logic            stallM,
  input  logic            flushM,
  input  logic            flushW,
  output logic [XLEN-1:0] hilo_rd_E,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            hilo_busy_E
);

  hilo_op_e        w_op;
  slot_t           w_e_ent, w_m_d, w_w_d, w_m, w_w;
  logic [XLEN-1:0] r_hi, r_lo;
  logic [XLEN-1:0] w_hi_fwd, w_lo_fwd;
  logic            w_hi_pend, w_lo_pend;

  assign w_op    = dec_op(hilo_we_E, mthi_E, mtlo_E);
  assign w_e_ent = enc_entry(w_op, hilo_in_E, rs_val_E);

  // Divider result not ready yet: M gets a bubble instead of the E entry.
  assign w_m_d = div_stallE ? '0 : w_e_ent;
  // M held: W gets a bubble so the held entry is not duplicated.
  assign w_w_d = stallM ? '0 : w_m;

  hilo_slot_reg u_slot_m (
    .clk(clk), .rst(rst), .i_clr(flushM), .i_hold(stallM), .i_d(w_m_d), .o_q(w_m)
  );

  hilo_slot_reg u_slot_w (
    .clk(clk), .rst(rst), .i_clr(flushW), .i_hold(1'b0), .i_d(w_w_d), .o_q(w_w)
  );

  // Commit reads the current W entry, so flushW only kills the incoming one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_w.valid) begin
      if (w_w.we_hi) r_hi <= w_w.hi;
      if (w_w.we_lo) r_lo <= w_w.lo;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

  assign w_hi_pend = (w_m.valid && w_m.we_hi) || (w_w.valid && w_w.we_hi);
  assign w_lo_pend = (w_m.valid && w_m.we_lo) || (w_w.valid && w_w.we_lo);

  // Youngest writer per half wins: M before W before architectural.
  always_comb begin
    w_hi_fwd = r_hi;
    w_lo_fwd = r_lo;
    if (FWD_EN) begin
      if (w_m.valid && w_m.we_hi)      w_hi_fwd = w_m.hi;
      else if (w_w.valid && w_w.we_hi) w_hi_fwd = w_w.hi;
      if (w_m.valid && w_m.we_lo)      w_lo_fwd = w_m.lo;
      else if (w_w.valid && w_w.we_lo) w_lo_fwd = w_w.lo;
    end
  end

  always_comb begin
    hilo_rd_E = '0;
    if (mfhi_E)      hilo_rd_E = w_hi_fwd;
    else if (mflo_E) hilo_rd_E = w_lo_fwd;
  end

  assign hilo_busy_E = !FWD_EN && ((mfhi_E && w_hi_pend) || (!mfhi_E && mflo_E && w_lo_pend));

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst, hilo_we_E, mthi_E, mtlo_E, mfhi_E, mflo_E;
  logic        div_stallE, stallM, flushM, flushW;
  logic [63:0] hilo_in_E;
  logic [31:0] rs_val_E;
  logic [31:0] rd1, hi1, lo1, rd0, hi0, lo0;
  logic        busy1, busy0;

  int nchk = 0;
  int nfail = 0;
  int hi_changes = 0;
  logic [31:0] last_hi;

  always #5 clk = ~clk;

  hilo_unit #(.FWD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .hilo_we_E(hilo_we_E), .hilo_in_E(hilo_in_E),
    .mthi_E(mthi_E), .mtlo_E(mtlo_E), .rs_val_E(rs_val_E), .mfhi_E(mfhi_E),
    .mflo_E(mflo_E), .div_stallE(div_stallE), .stallM(stallM), .flushM(flushM),
    .flushW(flushW), .hilo_rd_E(rd1), .hi_o(hi1), .lo_o(lo1), .hilo_busy_E(busy1)
  );

  hilo_unit #(.FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .hilo_we_E(hilo_we_E), .hilo_in_E(hilo_in_E),
    .mthi_E(mthi_E), .mtlo_E(mtlo_E), .rs_val_E(rs_val_E), .mfhi_E(mfhi_E),
    .mflo_E(mflo_E), .div_stallE(div_stallE), .stallM(stallM), .flushM(flushM),
    .flushW(flushW), .hilo_rd_E(rd0), .hi_o(hi0), .lo_o(lo0), .hilo_busy_E(busy0)
  );

  // Reference model: list of in-flight writes, index 0 = youngest (M), 1 = W.
  typedef struct {
    bit        v;
    bit        wh;
    bit        wl;
    bit [31:0] h;
    bit [31:0] l;
  } ent_t;

  ent_t      pend[2];
  bit [31:0] a_hi, a_lo;

  function automatic ent_t bubble();
    ent_t e;
    e.v = 0; e.wh = 0; e.wl = 0; e.h = 0; e.l = 0;
    return e;
  endfunction

  function automatic ent_t e_entry();
    ent_t e;
    e = bubble();
    if (hilo_we_E) begin
      e.v = 1; e.wh = 1; e.wl = 1; e.h = hilo_in_E[63:32]; e.l = hilo_in_E[31:0];
    end else if (mthi_E) begin
      e.v = 1; e.wh = 1; e.h = rs_val_E;
    end else if (mtlo_E) begin
      e.v = 1; e.wl = 1; e.l = rs_val_E;
    end
    return e;
  endfunction

  // Newest value of one half as seen by a reader: youngest in-flight writer, else architectural.
  function automatic bit [31:0] newest(input bit want_hi);
    for (int i = 0; i < 2; i++)
      if (pend[i].v && (want_hi ? pend[i].wh : pend[i].wl))
        return want_hi ? pend[i].h : pend[i].l;
    return want_hi ? a_hi : a_lo;
  endfunction

  function automatic bit pending(input bit want_hi);
    for (int i = 0; i < 2; i++)
      if (pend[i].v && (want_hi ? pend[i].wh : pend[i].wl)) return 1;
    return 0;
  endfunction

  function automatic bit [31:0] exp_rd(input bit fwd);
    if (mfhi_E) return fwd ? newest(1) : a_hi;
    if (mflo_E) return fwd ? newest(0) : a_lo;
    return 0;
  endfunction

  function automatic bit exp_busy0();
    if (mfhi_E) return pending(1);
    if (mflo_E) return pending(0);
    return 0;
  endfunction

  task automatic model_edge();
    ent_t nm, nw;
    if (rst) begin
      pend[0] = bubble(); pend[1] = bubble(); a_hi = 0; a_lo = 0;
      return;
    end
    if (pend[1].v) begin
      if (pend[1].wh) a_hi = pend[1].h;
      if (pend[1].wl) a_lo = pend[1].l;
    end
    nw = (flushW || stallM) ? bubble() : pend[0];
    if (flushM)          nm = bubble();
    else if (stallM)     nm = pend[0];
    else if (div_stallE) nm = bubble();
    else                 nm = e_entry();
    pend[0] = nm;
    pend[1] = nw;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hilo_we_E = 0; mthi_E = 0; mtlo_E = 0; mfhi_E = 0; mflo_E = 0;
    div_stallE = 0; stallM = 0; flushM = 0; flushW = 0; rst = 0;
    hilo_in_E = 0; rs_val_E = 0;
  endtask

  // Inputs are set after a negedge; combinational outputs checked just before
  // the posedge, registered outputs after the following negedge.
  task automatic cyc();
    #1;
    chk("rd_fwd", rd1, exp_rd(1));
    chk("busy_fwd", busy1, 0);
    chk("rd_nofwd", rd0, exp_rd(0));
    chk("busy_nofwd", busy0, exp_busy0());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("hi_o", hi1, a_hi);
    chk("lo_o", lo1, a_lo);
    chk("hi_o_nofwd", hi0, a_hi);
    chk("lo_o_nofwd", lo0, a_lo);
    if (hi1 !== last_hi) hi_changes++;
    last_hi = hi1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  initial begin
    pend[0] = bubble(); pend[1] = bubble(); a_hi = 0; a_lo = 0;
    last_hi = 0;
    idle();
    @(negedge clk);

    // Reset state
    do_reset();
    mfhi_E = 1; #1;
    chk("reset_hi", hi1, 0); chk("reset_lo", lo1, 0);
    chk("reset_rd", rd1, 0); chk("reset_busy", busy0, 0);
    idle();

    // MULT write visible after 3 edges
    hilo_we_E = 1; hilo_in_E = 64'h0000_0001_0000_0002; cyc();
    idle(); cyc();
    chk("mult_not_yet_hi", hi1, 0);
    cyc();
    chk("mult_hi", hi1, 32'h1); chk("mult_lo", lo1, 32'h2);

    // MTHI then MFHI: forwarded from M, busy without forwarding
    do_reset();
    mthi_E = 1; rs_val_E = 32'hDEAD_BEEF; cyc();
    idle(); mfhi_E = 1; #1;
    chk("mthi_fwd_rd", rd1, 32'hDEAD_BEEF);
    chk("mthi_hi_old", hi1, 0);
    chk("mthi_busy0", busy0, 1);
    begin
      int n = 0;
      while (busy0 === 1'b1 && n < 10) begin cyc(); n++; #1; end
      chk("busy_bound", (n < 10), 1);
    end
    chk("nofwd_rd_after", rd0, 32'hDEAD_BEEF);
    chk("nofwd_hi_after", hi0, 32'hDEAD_BEEF);
    idle();

    // MULT then MTLO then MFLO: M beats W, halves independent
    do_reset();
    hilo_we_E = 1; hilo_in_E = 64'hAAAA_AAAA_5555_5555; cyc();
    idle(); mtlo_E = 1; rs_val_E = 32'h1234_5678; cyc();
    idle(); mflo_E = 1; #1;
    chk("mflo_m_wins", rd1, 32'h1234_5678);
    mfhi_E = 1; mflo_E = 0; #1;
    chk("mfhi_from_w", rd1, 32'hAAAA_AAAA);
    idle(); cyc(); cyc(); cyc();
    chk("mix_hi", hi1, 32'hAAAA_AAAA); chk("mix_lo", lo1, 32'h1234_5678);

    // div stall: bubbles for 5 cycles, one capture afterwards
    do_reset();
    hi_changes = 0;
    hilo_we_E = 1; hilo_in_E = 64'hCAFE_0001_BEEF_0002; div_stallE = 1;
    repeat (5) cyc();
    chk("div_no_commit", hi1, 0);
    div_stallE = 0; cyc();
    idle(); repeat (5) cyc();
    chk("div_hi", hi1, 32'hCAFE_0001); chk("div_lo", lo1, 32'hBEEF_0002);
    chk("div_hi_changes", hi_changes, 1);

    // flushM with stallM kills the entry
    do_reset();
    hilo_we_E = 1; hilo_in_E = 64'h1111_1111_2222_2222; cyc();
    idle(); flushM = 1; stallM = 1; cyc();
    idle(); repeat (3) cyc();
    chk("flushM_hi", hi1, 0); chk("flushM_lo", lo1, 0);

    // flushW while W commits: W entry still commits
    do_reset();
    hilo_we_E = 1; hilo_in_E = 64'h3333_3333_4444_4444; cyc();
    idle(); cyc();
    flushW = 1; cyc();
    idle();
    chk("flushW_commit_hi", hi1, 32'h3333_3333);

    // reset mid-operation discards pending writes
    do_reset();
    mthi_E = 1; rs_val_E = 32'h5555_0000; cyc();
    idle(); cyc();
    rst = 1; cyc(); rst = 0;
    idle(); repeat (2) cyc();
    chk("rst_mid_hi", hi1, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      hilo_we_E  = ($urandom_range(0, 3) == 0);
      mthi_E     = ($urandom_range(0, 3) == 0);
      mtlo_E     = ($urandom_range(0, 3) == 0);
      mfhi_E     = $urandom_range(0, 1);
      mflo_E     = $urandom_range(0, 1);
      div_stallE = ($urandom_range(0, 5) == 0);
      stallM     = ($urandom_range(0, 5) == 0);
      flushM     = ($urandom_range(0, 9) == 0);
      flushW     = ($urandom_range(0, 9) == 0);
      hilo_in_E  = {$urandom, $urandom};
      rs_val_E   = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
